// File: rtl/legup_board_pkg.sv
// rtl/legup_board_pkg.sv - shared FSM state codes and seven-segment glyph table for the board monitor
package legup_board_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_START   = 4'd1,
    ST_RUN     = 4'd2,
    ST_DONE    = 4'd3,
    ST_TIMEOUT = 4'd4
  } state_e;

  // Active-high glyphs, bit order {g,f,e,d,c,b,a}; entry 15 is leftmost.
  localparam logic [15:0][6:0] SEG_GLYPHS = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/hex7seg_decoder.sv
// rtl/hex7seg_decoder.sv - one hex nibble to seven-segment pattern, polarity selectable
module hex7seg_decoder
  import legup_board_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_ACTIVE_LOW ? ~SEG_GLYPHS[nibble] : SEG_GLYPHS[nibble];

endmodule

// File: rtl/legup_result_monitor.sv
// rtl/legup_result_monitor.sv - starts the LegUp core, times the run, shows result or cycle count on HEX/LEDG
module legup_result_monitor
  import legup_board_pkg::*;
#(
  parameter int unsigned START_DELAY    = 16,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'hFFFF_FFFF,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        finish,
  input  logic [31:0] return_val,
  input  logic        sw_sel,
  output logic        start,
  output logic [3:0]  state,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5,
  output logic [6:0]  hex6,
  output logic [6:0]  hex7,
  output logic [7:0]  ledg
);

  localparam logic [31:0] DLY_LAST = 32'(START_DELAY - 1);
  localparam logic [6:0]  SEG_ZERO = SEG_ACTIVE_LOW ? ~SEG_GLYPHS[0] : SEG_GLYPHS[0];

  state_e      state_q, state_d;
  logic [31:0] dly_q, dly_d;
  logic [31:0] cyc_q, cyc_d;
  logic [31:0] cyc_inc;
  logic [31:0] result_q, result_d;
  logic [31:0] count_q, count_d;
  logic        sw_sel_q, sw_sel_d;
  logic [7:0]  ledg_q, ledg_d;
  logic [6:0]  hex_q [8];
  logic [6:0]  hex_d [8];
  logic [6:0]  seg_raw [8];
  logic [31:0] sel_word;

  assign cyc_inc = cyc_q + 32'd1;

  always_comb begin
    state_d  = state_q;
    dly_d    = dly_q;
    cyc_d    = cyc_q;
    result_d = result_q;
    count_d  = count_q;
    start    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (dly_q == DLY_LAST) begin
          state_d = ST_START;
        end else begin
          dly_d = dly_q + 32'd1;
        end
      end
      ST_START: begin
        start   = 1'b1;
        cyc_d   = 32'd0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        cyc_d = cyc_inc;
        // A finish on the last allowed cycle still counts as a completed run.
        if (finish) begin
          result_d = return_val;
          count_d  = cyc_inc;
          state_d  = ST_DONE;
        end else if (cyc_inc == TIMEOUT_CYCLES) begin
          count_d = TIMEOUT_CYCLES;
          state_d = ST_TIMEOUT;
        end
      end
      default: begin
      end
    endcase
  end

  assign sel_word = sw_sel_q ? count_q : result_q;

  for (genvar n = 0; n < 8; n++) begin : g_digit
    hex7seg_decoder #(
      .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
    ) u_dec (
      .nibble(sel_word[4*n +: 4]),
      .seg   (seg_raw[n])
    );
  end

  always_comb begin
    sw_sel_d = sw_sel;
    ledg_d   = {4'b0000, sw_sel_q, state_q == ST_RUN, state_q == ST_TIMEOUT, state_q == ST_DONE};
    for (int n = 0; n < 8; n++) begin
      hex_d[n] = seg_raw[n];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      dly_q    <= 32'd0;
      cyc_q    <= 32'd0;
      result_q <= 32'd0;
      count_q  <= 32'd0;
      sw_sel_q <= 1'b0;
      ledg_q   <= 8'h00;
      for (int n = 0; n < 8; n++) begin
        hex_q[n] <= SEG_ZERO;
      end
    end else begin
      state_q  <= state_d;
      dly_q    <= dly_d;
      cyc_q    <= cyc_d;
      result_q <= result_d;
      count_q  <= count_d;
      sw_sel_q <= sw_sel_d;
      ledg_q   <= ledg_d;
      for (int n = 0; n < 8; n++) begin
        hex_q[n] <= hex_d[n];
      end
    end
  end

  assign state = state_q;
  assign ledg  = ledg_q;
  assign hex0  = hex_q[0];
  assign hex1  = hex_q[1];
  assign hex2  = hex_q[2];
  assign hex3  = hex_q[3];
  assign hex4  = hex_q[4];
  assign hex5  = hex_q[5];
  assign hex6  = hex_q[6];
  assign hex7  = hex_q[7];

endmodule

// File: tb/tb_legup_result_monitor.sv
// tb/tb_legup_result_monitor.sv - self-checking bench for legup_result_monitor
module tb_legup_result_monitor;

  localparam int SD = 4;
  localparam int TO = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        finish = 1'b0;
  logic        sw_sel = 1'b0;
  logic [31:0] return_val = 32'd0;
  logic        start;
  logic [3:0]  state;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
  logic [7:0]  ledg;
  logic [55:0] hex_all;

  int errors = 0;
  int checks = 0;

  logic        fin_v [0:63];
  logic [31:0] val_v [0:63];

  typedef struct {
    logic       rst;
    logic       fin;
    logic [3:0] st;
    logic       stt;
    logic [7:0] led;
  } vec_t;
  vec_t tbl [12];

  legup_result_monitor #(
    .START_DELAY   (SD),
    .TIMEOUT_CYCLES(32'd20),
    .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .finish    (finish),
    .return_val(return_val),
    .sw_sel    (sw_sel),
    .start     (start),
    .state     (state),
    .hex0      (hex0),
    .hex1      (hex1),
    .hex2      (hex2),
    .hex3      (hex3),
    .hex4      (hex4),
    .hex5      (hex5),
    .hex6      (hex6),
    .hex7      (hex7),
    .ledg      (ledg)
  );

  assign hex_all = {hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0};

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] glyph_on(input logic [3:0] n);
    case (n)
      4'h0: return 7'b0111111;
      4'h1: return 7'b0000110;
      4'h2: return 7'b1011011;
      4'h3: return 7'b1001111;
      4'h4: return 7'b1100110;
      4'h5: return 7'b1101101;
      4'h6: return 7'b1111101;
      4'h7: return 7'b0000111;
      4'h8: return 7'b1111111;
      4'h9: return 7'b1101111;
      4'hA: return 7'b1110111;
      4'hB: return 7'b1111100;
      4'hC: return 7'b0111001;
      4'hD: return 7'b1011110;
      4'hE: return 7'b1111001;
      default: return 7'b1110001;
    endcase
  endfunction

  function automatic logic [55:0] disp(input logic [31:0] w);
    logic [55:0] d;
    for (int n = 0; n < 8; n++) d[7*n +: 7] = ~glyph_on(w[4*n +: 4]);
    return d;
  endfunction

  // Expected state code in cycle j after reset release, given the run outcome.
  function automatic logic [3:0] st_at(input int j, input int term_j, input bit done);
    if (j < SD) return 4'd0;
    if (j == SD) return 4'd1;
    if (j < term_j) return 4'd2;
    return done ? 4'd3 : 4'd4;
  endfunction

  function automatic logic [7:0] led_of(input logic [3:0] s);
    case (s)
      4'd2: return 8'h04;
      4'd3: return 8'h01;
      4'd4: return 8'h02;
      default: return 8'h00;
    endcase
  endfunction

  task automatic run_trial(input string tag);
    int          k;
    bit          done;
    int          term_j;
    logic [31:0] exp_count, exp_result;
    k = 0;
    for (int i = 1; i <= TO; i++) begin
      if (fin_v[SD + i] && k == 0) k = i;
    end
    done       = (k != 0);
    exp_count  = done ? 32'(k) : 32'(TO);
    exp_result = done ? val_v[SD + k] : 32'd0;
    term_j     = (done ? k : TO) + SD + 1;

    sw_sel = 1'b0;
    finish = 1'b0;
    reset  = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int j = 0; j < 40; j++) begin
      finish     = fin_v[j];
      return_val = val_v[j];
      chk($sformatf("%s state j=%0d", tag, j), state, st_at(j, term_j, done));
      chk($sformatf("%s start j=%0d", tag, j), start, (j == SD));
      chk($sformatf("%s ledg j=%0d", tag, j), ledg, led_of(st_at(j - 1, term_j, done)));
      tick();
    end
    finish = 1'b0;
    chk({tag, " result digits"}, hex_all, disp(exp_result));
    chk({tag, " final ledg"}, ledg, done ? 8'h01 : 8'h02);
    sw_sel = 1'b1;
    tick();
    chk({tag, " digits held 1 cycle"}, hex_all, disp(exp_result));
    tick();
    chk({tag, " count digits"}, hex_all, disp(exp_count));
    chk({tag, " ledg with sw"}, ledg, (done ? 8'h01 : 8'h02) | 8'h08);
  endtask

  initial begin
    int          pcts [4];
    logic [3:0]  seq [7];
    pcts = '{0, 4, 12, 40};
    seq  = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd2};

    tbl[0]  = '{1'b1, 1'b0, 4'd0, 1'b0, 8'h00};
    tbl[1]  = '{1'b1, 1'b1, 4'd0, 1'b0, 8'h00};
    tbl[2]  = '{1'b0, 1'b1, 4'd0, 1'b0, 8'h00};
    tbl[3]  = '{1'b0, 1'b1, 4'd0, 1'b0, 8'h00};
    tbl[4]  = '{1'b0, 1'b1, 4'd0, 1'b0, 8'h00};
    tbl[5]  = '{1'b0, 1'b1, 4'd1, 1'b1, 8'h00};
    tbl[6]  = '{1'b0, 1'b1, 4'd2, 1'b0, 8'h00};
    tbl[7]  = '{1'b0, 1'b0, 4'd2, 1'b0, 8'h04};
    tbl[8]  = '{1'b0, 1'b0, 4'd2, 1'b0, 8'h04};
    tbl[9]  = '{1'b0, 1'b1, 4'd3, 1'b0, 8'h04};
    tbl[10] = '{1'b0, 1'b0, 4'd3, 1'b0, 8'h01};
    tbl[11] = '{1'b0, 1'b1, 4'd3, 1'b0, 8'h01};

    tick();
    chk("reset hex", hex_all, {8{7'h40}});
    return_val = 32'h0000_0042;
    for (int i = 0; i < 12; i++) begin
      reset  = tbl[i].rst;
      finish = tbl[i].fin;
      tick();
      chk($sformatf("tbl state row=%0d", i), state, tbl[i].st);
      chk($sformatf("tbl start row=%0d", i), start, tbl[i].stt);
      chk($sformatf("tbl ledg row=%0d", i), ledg, tbl[i].led);
    end
    chk("tbl captured result", hex_all, disp(32'h0000_0042));

    // Finish ten cycles after start with 0xC8.
    for (int j = 0; j < 64; j++) begin fin_v[j] = 1'b0; val_v[j] = 32'd0; end
    fin_v[SD + 10] = 1'b1;
    val_v[SD + 10] = 32'h0000_00C8;
    run_trial("c8");
    chk("c8 count literal", hex_all, {{7{7'h40}}, 7'h08});
    chk("c8 ledg literal", ledg, 8'h09);

    // No finish until well after timeout.
    for (int j = 0; j < 64; j++) begin
      fin_v[j] = (j > SD + TO);
      val_v[j] = $urandom;
    end
    run_trial("timeout");
    chk("timeout count literal", hex_all, {{6{7'h40}}, 7'h79, 7'h19});

    // finish high through IDLE/START and the first RUN cycle, then again later.
    for (int j = 0; j < 64; j++) begin
      fin_v[j] = (j <= SD + 1) || (j >= SD + 4);
      val_v[j] = $urandom;
    end
    val_v[SD + 1] = 32'h1234_5678;
    run_trial("early");
    chk("early count literal", hex_all, {{7{7'h40}}, 7'h06 ^ 7'h7F});
    sw_sel = 1'b0;
    tick();
    tick();
    chk("early result literal", hex_all, disp(32'h1234_5678));

    for (int t = 0; t < 12; t++) begin
      for (int j = 0; j < 64; j++) begin
        fin_v[j] = ($urandom_range(0, 99) < pcts[t % 4]);
        val_v[j] = $urandom;
      end
      run_trial($sformatf("rnd%0d", t));
    end

    // Reset asserted for one cycle in the middle of a run.
    sw_sel = 1'b0;
    finish = 1'b0;
    reset  = 1'b1;
    tick();
    reset = 1'b0;
    for (int j = 0; j < 10; j++) tick();
    chk("midrun running", ledg, 8'h04);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort state", state, 4'd0);
    chk("abort start", start, 1'b0);
    chk("abort ledg", ledg, 8'h00);
    chk("abort hex", hex_all, {8{7'h40}});
    for (int j = 0; j < 7; j++) begin
      chk($sformatf("restart state j=%0d", j), state, seq[j]);
      chk($sformatf("restart start j=%0d", j), start, (j == SD));
      tick();
    end
    finish     = 1'b1;
    return_val = 32'h0000_00A5;
    tick();
    finish = 1'b0;
    tick();
    tick();
    chk("restart state done", state, 4'd3);
    chk("restart result", hex_all, disp(32'h0000_00A5));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
